// File: rtl/intersection_sequencer.sv
// Moore controller for a highway / country-road crossing: debounced country sensor,
// latched pedestrian requests and emergency preemption that waits for clearance intervals.
module intersection_sequencer #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_T     = 5,
    parameter int unsigned DEB       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_ARH = 3'd2,
        S_PED = 3'd3,
        S_CG  = 3'd4,
        S_CY  = 3'd5,
        S_ARC = 3'd6,
        S_EMG = 3'd7
    } state_t;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    localparam logic [7:0] GMIN_LAST = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_LAST = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_LAST  = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_LAST   = 8'(ALLRED_T - 1);
    localparam logic [7:0] PED_LAST  = 8'(PED_T - 1);
    localparam logic [7:0] DEB_LAST  = 8'(DEB - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       ped_pending_q, ped_pending_d;
    logic       sync1_q, sync2_q, sensor_db_q;
    logic [7:0] db_cnt_q;
    logic [1:0] hwy_q, cntry_q;
    logic       walk_q, ped_ack_q;
    logic [2:0] phase_q;

    // Lamp pattern {hwy, cntry, walk} for a state.
    function automatic logic [4:0] lamps(input state_t s);
        case (s)
            S_HG:    lamps = {LAMP_GRN, LAMP_RED, 1'b0};
            S_HY:    lamps = {LAMP_YEL, LAMP_RED, 1'b0};
            S_PED:   lamps = {LAMP_RED, LAMP_RED, 1'b1};
            S_CG:    lamps = {LAMP_RED, LAMP_GRN, 1'b0};
            S_CY:    lamps = {LAMP_RED, LAMP_YEL, 1'b0};
            default: lamps = {LAMP_RED, LAMP_RED, 1'b0};
        endcase
    endfunction

    // Sensor synchronizer and debouncer: toggle only after DEB consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sensor_db_q <= 1'b0;
            db_cnt_q    <= 8'd0;
        end else begin
            sync1_q <= sensor;
            sync2_q <= sync1_q;
            if (sync2_q == sensor_db_q) begin
                db_cnt_q <= 8'd0;
            end else if (db_cnt_q == DEB_LAST) begin
                sensor_db_q <= ~sensor_db_q;
                db_cnt_q    <= 8'd0;
            end else begin
                db_cnt_q <= db_cnt_q + 8'd1;
            end
        end
    end

    // Next-state, phase timer and pedestrian latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HG:  if (emerg || (timer_q >= GMIN_LAST && (sensor_db_q || ped_pending_q))) state_d = S_HY;
                   else state_d = S_HG;
            S_HY:  if (timer_q == YEL_LAST) state_d = S_ARH;
                   else state_d = S_HY;
            S_ARH: if (timer_q != AR_LAST) state_d = S_ARH;
                   else if (emerg)         state_d = S_EMG;
                   else if (ped_pending_q) state_d = S_PED;
                   else                    state_d = S_CG;
            S_PED: if (emerg)                    state_d = S_EMG;
                   else if (timer_q != PED_LAST) state_d = S_PED;
                   else if (sensor_db_q)         state_d = S_CG;
                   else                          state_d = S_HG;
            S_CG:  if (emerg || timer_q == GMAX_LAST || (timer_q >= GMIN_LAST && !sensor_db_q)) state_d = S_CY;
                   else state_d = S_CG;
            S_CY:  if (timer_q == YEL_LAST) state_d = S_ARC;
                   else state_d = S_CY;
            S_ARC: if (timer_q != AR_LAST) state_d = S_ARC;
                   else if (emerg)         state_d = S_EMG;
                   else                    state_d = S_HG;
            S_EMG: if (emerg) state_d = S_EMG;
                   else       state_d = S_HG;
            default: state_d = S_HG;
        endcase

        // Saturate so an indefinite HG/EMG dwell never wraps back below GREEN_MIN.
        if (state_d != state_q)     timer_d = 8'd0;
        else if (timer_q == 8'hFF)  timer_d = timer_q;
        else                        timer_d = timer_q + 8'd1;

        if (state_d == S_PED && state_q != S_PED)  ped_pending_d = 1'b0;
        else if (ped_req && state_q != S_PED)      ped_pending_d = 1'b1;
        else                                       ped_pending_d = ped_pending_q;
    end

    // State register; outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HG;
            timer_q       <= 8'd0;
            ped_pending_q <= 1'b0;
            hwy_q         <= LAMP_GRN;
            cntry_q       <= LAMP_RED;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
            phase_q       <= 3'd0;
        end else begin
            state_q                  <= state_d;
            timer_q                  <= timer_d;
            ped_pending_q            <= ped_pending_d;
            {hwy_q, cntry_q, walk_q} <= lamps(state_d);
            ped_ack_q                <= (state_d == S_PED) && (state_q != S_PED);
            phase_q                  <= state_d;
        end
    end

    assign hwy     = hwy_q;
    assign cntry   = cntry_q;
    assign walk    = walk_q;
    assign ped_ack = ped_ack_q;
    assign phase   = phase_q;
endmodule
